io_bus_arbiter: RTL
===================

Name: io_bus_arbiter

Overview:
- Shares the single non-cached I/O bus (peripheral register access, io_bus_interface master side) between the I/O request ports of NUM_REQUESTERS cores.
- Each request (ioreq_packet_t fields) goes through a round-robin arbiter, runs one bus transaction, and returns one iorsp_packet_t-style response tagged with the originating core and thread.
- Sits between the per-core I/O request ports and the external I/O bus.

Parameters:
- NUM_REQUESTERS, 4, number of requesting cores (1..16; requester index maps to core_id_t).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ioreq_valid  in  NUM_REQUESTERS  per-requester request valid; held until accepted
- ioreq_store  in  NUM_REQUESTERS  1 = store, 0 = load
- ioreq_thread_idx  in  NUM_REQUESTERS x $clog2(THREADS_PER_CORE)  issuing local thread
- ioreq_address  in  NUM_REQUESTERS x 32  register address
- ioreq_value  in  NUM_REQUESTERS x 32  store data
- ioreq_ready  out  NUM_REQUESTERS  one-hot accept; handshake = valid & ready
- io_write_en  out  1  bus write strobe
- io_read_en  out  1  bus read strobe
- io_address  out  32  bus address
- io_write_data  out  32  bus write data
- io_read_data  in  32  valid the cycle after io_read_en
- iorsp_valid  out  1  response pulse
- iorsp_core  out  4  core_id_t of the requester
- iorsp_thread_idx  out  $clog2(THREADS_PER_CORE)  thread of the request
- iorsp_read_value  out  32  load data; 0 for stores

Behaviour:
- State machine: IDLE, ISSUE, WAIT_READ, RESPOND. Reset enters IDLE.
- IDLE:
  - ioreq_ready is combinational, at most one bit set, and only in IDLE.
  - If any ioreq_valid is set, grant the round-robin winner: search starts at last_grant+1 and wraps modulo NUM_REQUESTERS.
  - On grant: latch store, thread_idx, address, value and the requester index. Set last_grant to the winner. Go to ISSUE.
- ISSUE (one cycle):
  - io_write_en = store, io_read_en = !store. Exactly one strobe, asserted for exactly one cycle.
  - io_address and io_write_data are driven from the latch.
  - Store goes to RESPOND; load goes to WAIT_READ.
- WAIT_READ: capture io_read_data into the response register, then go to RESPOND.
- RESPOND:
  - iorsp_valid = 1 for one cycle; iorsp_core = granted index zero-extended to 4 bits; iorsp_thread_idx from the latch.
  - iorsp_read_value = captured data for a load, 0 for a store.
  - Go to IDLE.
- Latency from the handshake cycle (C) to iorsp_valid: store C+2, load C+3.
- Throughput: a new grant is possible in the cycle after RESPOND. Peak rate is one store per 3 cycles or one load per 4 cycles.
- Outside ISSUE: strobes = 0, io_address/io_write_data = 0.
- Outside RESPOND: iorsp_* = 0.
- Reset values: all outputs 0, state IDLE, last_grant = NUM_REQUESTERS-1 (requester 0 wins first).
- Reset mid-operation: the in-flight request is dropped and no response is produced. A requester still holding valid is re-arbitrated after reset.
- Requests arriving outside IDLE: not accepted (ready = 0). They stay pending with no loss.
- Sole requester: granted every time it is valid in IDLE; no starvation.
- NUM_REQUESTERS = 1: the arbiter degenerates to a pass-through; the pointer is fixed at 0.

Optional Feature:
- Macro IO_BUS_ARB_STATS_EN adds three 32-bit outputs: perf_io_loads, perf_io_stores, perf_io_contention.
  - Loads/stores increment on each ISSUE cycle of the matching type.
  - Contention increments each cycle in which at least one ioreq_valid is pending but not accepted.
  - All three reset to 0 and wrap modulo 2^32.
- Without the macro, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Requester 2 store, addr 0x110, value 0xDEADBEEF -> io_write_en=1 for one cycle with those values, io_read_en=0; iorsp_valid at C+2 with core=2 and read_value=0.
- Requester 0 load, thread 3, addr 0x40; bus returns 0x12345678 the next cycle -> iorsp_valid at C+3 with core=0, thread=3, read_value=0x12345678.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each ready is a one-cycle pulse; no two strobes overlap.
- Requesters 1 and 3 valid, last_grant=1 -> 3 granted first, then 1.
- Reset asserted during WAIT_READ -> every output 0 immediately; no iorsp_valid; the pending requester is granted again after reset.
- With IO_BUS_ARB_STATS_EN: 2 loads, 1 store, 2 requesters contending -> perf_io_loads=2, perf_io_stores=1, perf_io_contention equals the cycle-exact count of cycles with a pending, unaccepted request.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter that shares the single non-cached I/O bus between core request ports.
// Optional performance counters are enabled with the IO_BUS_ARB_STATS_EN macro.
module io_bus_arbiter #(
    parameter int unsigned NUM_REQUESTERS   = 4,
    parameter int unsigned THREADS_PER_CORE = 4,
    localparam int unsigned THREAD_W = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1,
    localparam int unsigned IDX_W    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQUESTERS-1:0]                ioreq_valid,
    input  logic [NUM_REQUESTERS-1:0]                ioreq_store,
    input  logic [NUM_REQUESTERS-1:0][THREAD_W-1:0]  ioreq_thread_idx,
    input  logic [NUM_REQUESTERS-1:0][31:0]          ioreq_address,
    input  logic [NUM_REQUESTERS-1:0][31:0]          ioreq_value,
    output logic [NUM_REQUESTERS-1:0]                ioreq_ready,
    output logic                                     io_write_en,
    output logic                                     io_read_en,
    output logic [31:0]                              io_address,
    output logic [31:0]                              io_write_data,
    input  logic [31:0]                              io_read_data,
    output logic                                     iorsp_valid,
    output logic [3:0]                               iorsp_core,
    output logic [THREAD_W-1:0]                      iorsp_thread_idx,
    output logic [31:0]                              iorsp_read_value
`ifdef IO_BUS_ARB_STATS_EN
    ,
    output logic [31:0]                              perf_io_loads,
    output logic [31:0]                              perf_io_stores,
    output logic [31:0]                              perf_io_contention
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ, RESPOND} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic                accept;
    logic                lat_store;
    logic [THREAD_W-1:0] lat_thread;
    logic [31:0]         lat_address;
    logic [31:0]         lat_value;
    logic [IDX_W-1:0]    lat_idx;
    logic [31:0]         rsp_data;

    // Round-robin search starting one past the last winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQUESTERS; i++) begin
            automatic logic [IDX_W-1:0] cand = IDX_W'((32'(last_grant) + i) % NUM_REQUESTERS);
            if (!grant_valid && ioreq_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Ready is held low during reset so no handshake can slip through.
    assign accept      = (state_q == IDLE) && grant_valid && !reset;
    assign ioreq_ready = accept ? (NUM_REQUESTERS'(1) << grant_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = ISSUE;
            ISSUE:     state_d = lat_store ? RESPOND : WAIT_READ;
            WAIT_READ: state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Request latch, arbitration pointer and load data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= IDX_W'(NUM_REQUESTERS - 1);
            lat_store   <= 1'b0;
            lat_thread  <= '0;
            lat_address <= '0;
            lat_value   <= '0;
            lat_idx     <= '0;
            rsp_data    <= '0;
        end else begin
            if (accept) begin
                last_grant  <= grant_idx;
                lat_store   <= ioreq_store[grant_idx];
                lat_thread  <= ioreq_thread_idx[grant_idx];
                lat_address <= ioreq_address[grant_idx];
                lat_value   <= ioreq_value[grant_idx];
                lat_idx     <= grant_idx;
            end
            if (state_q == WAIT_READ) begin
                rsp_data <= io_read_data;
            end
        end
    end

    always_comb begin
        io_write_en      = 1'b0;
        io_read_en       = 1'b0;
        io_address       = '0;
        io_write_data    = '0;
        iorsp_valid      = 1'b0;
        iorsp_core       = '0;
        iorsp_thread_idx = '0;
        iorsp_read_value = '0;
        case (state_q)
            ISSUE: begin
                io_write_en   = lat_store;
                io_read_en    = !lat_store;
                io_address    = lat_address;
                io_write_data = lat_value;
            end
            RESPOND: begin
                iorsp_valid      = 1'b1;
                iorsp_core       = 4'(lat_idx);
                iorsp_thread_idx = lat_thread;
                iorsp_read_value = lat_store ? 32'd0 : rsp_data;
            end
            default: ;
        endcase
    end

`ifdef IO_BUS_ARB_STATS_EN
    // Contention: some request is pending this cycle but not being accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_io_loads      <= '0;
            perf_io_stores     <= '0;
            perf_io_contention <= '0;
        end else begin
            if (state_q == ISSUE) begin
                if (lat_store) perf_io_stores <= perf_io_stores + 32'd1;
                else           perf_io_loads  <= perf_io_loads + 32'd1;
            end
            if (|(ioreq_valid & ~ioreq_ready)) begin
                perf_io_contention <= perf_io_contention + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule
